// File: rtl/systolic_pkg.sv
// Shared types and size helpers for the systolic array sequencing controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } sched_state_e;

  // A operands then B operands, both row-major.
  function automatic int beat_count(input int array_width, input int array_height);
    return 2 * array_width * array_height;
  endfunction

  // The C matrix is square in the array height.
  function automatic int result_count(input int array_height);
    return array_height * array_height;
  endfunction

  // Wide enough to hold the terminal count itself; never narrower than one bit.
  function automatic int cnt_width(input int terminal);
    return (terminal < 1) ? 1 : $clog2(terminal + 1);
  endfunction

endpackage

// File: rtl/systolic_sched_if.sv
// Host, operand and result handshake bundle around the sequencing controller.
// Latency: n/a (wires only).
// Backpressure: carried by the ready/yumi signals in the bundle.
interface systolic_sched_if #(
  parameter int width_p        = 8,
  parameter int array_height_p = 8
);
  localparam int idx_w_lp = $clog2(array_height_p);

  logic                start_i;
  logic                busy_o;
  logic                done_o;
  logic                err_o;
  logic                op_valid_i;
  logic [width_p-1:0]  op_data_i;
  logic                op_ready_o;
  logic                arr_en_o;
  logic                arr_flush_o;
  logic                arr_valid_o;
  logic [width_p-1:0]  arr_data_o;
  logic                arr_ready_i;
  logic                arr_valid_i;
  logic [width_p-1:0]  arr_data_i;
  logic                arr_yumi_o;
  logic                res_valid_o;
  logic [width_p-1:0]  res_data_o;
  logic [idx_w_lp-1:0] res_row_o;
  logic [idx_w_lp-1:0] res_col_o;
  logic                res_ready_i;

  // Controller side.
  modport master (
    input  start_i, op_valid_i, op_data_i, arr_ready_i, arr_valid_i, arr_data_i, res_ready_i,
    output busy_o, done_o, err_o, op_ready_o, arr_en_o, arr_flush_o, arr_valid_o, arr_data_o,
           arr_yumi_o, res_valid_o, res_data_o, res_row_o, res_col_o
  );

  // Host / array side.
  modport slave (
    output start_i, op_valid_i, op_data_i, arr_ready_i, arr_valid_i, arr_data_i, res_ready_i,
    input  busy_o, done_o, err_o, op_ready_o, arr_en_o, arr_flush_o, arr_valid_o, arr_data_o,
           arr_yumi_o, res_valid_o, res_data_o, res_row_o, res_col_o
  );

endinterface

// File: rtl/sched_counter.sv
// Up-counter with synchronous clear/enable and an equality terminal-count flag.
// Latency: count updates one edge after en_i; tc_o is combinational on the count.
// Backpressure: none; the owner gates en_i.
module sched_counter #(
  parameter int width_p = 8,
  parameter int limit_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o,
  output logic               tc_o
);
  localparam logic [width_p-1:0] limit_lp = width_p'(limit_p);

  // Clear has priority over enable so a wrap-and-count cycle reads as a wrap.
  always_ff @(posedge clk_i) begin
    if (!reset_ni)  count_o <= '0;
    else if (clr_i) count_o <= '0;
    else if (en_i)  count_o <= count_o + width_p'(1);
  end

  assign tc_o = (count_o == limit_lp);

endmodule

// File: rtl/systolic_sched.sv
// Sequences one job: load A/B beats, wait a fixed compute interval, drain C tagged by row/col.
// Latency: zero-cycle pass-through on both streams; control outputs registered off the FSM.
// Backpressure: arr_ready_i stalls the operand stream, res_ready_i stalls arr_yumi_o.
// Optional drain watchdog with err_o reporting: define SYSTOLIC_SCHED_TIMEOUT_EN.
module systolic_sched
  import systolic_pkg::*;
#(
  parameter int width_p          = 8,
  parameter int array_width_p    = 8,
  parameter int array_height_p   = 8,
  parameter int compute_cycles_p = 24,
  parameter int timeout_cycles_p = 256
) (
  input logic clk_i,
  input logic reset_ni,
  systolic_sched_if.master bus
);
  localparam int beats_lp   = beat_count(array_width_p, array_height_p);
  localparam int beat_w_lp  = cnt_width(beats_lp);
  localparam int cmp_w_lp   = cnt_width(compute_cycles_p);
  localparam int cmp_lim_lp = (compute_cycles_p > 0) ? compute_cycles_p - 1 : 0;
  localparam int idx_w_lp   = $clog2(array_height_p);

  sched_state_e state_q, state_n;
  logic busy_q, done_q, en_q, flush_q;
  logic in_load, in_drain, start_acc, beat_fire, res_fire;
  logic beat_tc, cmp_tc, col_tc, row_tc, timeout;
  logic [beat_w_lp-1:0] unused_beat_cnt;
  logic [cmp_w_lp-1:0]  unused_cmp_cnt;
  logic [idx_w_lp-1:0]  row_cnt, col_cnt;

  assign in_load   = (state_q == S_LOAD);
  assign in_drain  = (state_q == S_DRAIN);
  assign start_acc = (state_q == S_IDLE) && bus.start_i;
  assign beat_fire = in_load && bus.op_valid_i && bus.arr_ready_i;
  assign res_fire  = in_drain && bus.arr_valid_i && bus.res_ready_i;

  sched_counter #(.width_p(beat_w_lp), .limit_p(beats_lp - 1)) u_beat (
    .clk_i, .reset_ni, .clr_i(start_acc), .en_i(beat_fire),
    .count_o(unused_beat_cnt), .tc_o(beat_tc)
  );

  sched_counter #(.width_p(cmp_w_lp), .limit_p(cmp_lim_lp)) u_cmp (
    .clk_i, .reset_ni, .clr_i(start_acc), .en_i(state_q == S_COMPUTE),
    .count_o(unused_cmp_cnt), .tc_o(cmp_tc)
  );

  // Column wraps on its last value; row only advances on a column wrap and parks on its last value.
  sched_counter #(.width_p(idx_w_lp), .limit_p(array_height_p - 1)) u_col (
    .clk_i, .reset_ni, .clr_i(start_acc || (res_fire && col_tc)), .en_i(res_fire),
    .count_o(col_cnt), .tc_o(col_tc)
  );

  sched_counter #(.width_p(idx_w_lp), .limit_p(array_height_p - 1)) u_row (
    .clk_i, .reset_ni, .clr_i(start_acc), .en_i(res_fire && col_tc && !row_tc),
    .count_o(row_cnt), .tc_o(row_tc)
  );

`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
  localparam int wd_w_lp = cnt_width(timeout_cycles_p);
  logic [wd_w_lp-1:0] unused_wd_cnt;
  logic               err_q;

  // Counts consecutive DRAIN cycles without a result handshake.
  sched_counter #(.width_p(wd_w_lp), .limit_p(timeout_cycles_p)) u_wd (
    .clk_i, .reset_ni, .clr_i(!in_drain || res_fire), .en_i(in_drain),
    .count_o(unused_wd_cnt), .tc_o(timeout)
  );

  // Sticky timeout flag, cleared only by an accepted start.
  always_ff @(posedge clk_i) begin
    if (!reset_ni)                               err_q <= 1'b0;
    else if (start_acc)                          err_q <= 1'b0;
    else if (in_drain && !res_fire && timeout)   err_q <= 1'b1;
  end

  assign bus.err_o = err_q;
`else
  assign timeout   = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  // Next-state selection; a handshake in the timeout cycle takes precedence over the watchdog.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE:    if (bus.start_i) state_n = S_LOAD;
      S_LOAD:    if (beat_fire && beat_tc) state_n = (compute_cycles_p == 0) ? S_DRAIN : S_COMPUTE;
      S_COMPUTE: if (cmp_tc) state_n = S_DRAIN;
      S_DRAIN:   if ((res_fire && row_tc && col_tc) || (!res_fire && timeout)) state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // State register with control outputs registered from the next state.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_n;
      busy_q  <= (state_n == S_LOAD) || (state_n == S_COMPUTE) || (state_n == S_DRAIN);
      done_q  <= (state_n == S_DONE);
      en_q    <= (state_n != S_IDLE);
      flush_q <= (state_n == S_DRAIN);
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.arr_en_o    = en_q;
  assign bus.arr_flush_o = flush_q;

  assign bus.op_ready_o  = in_load && bus.arr_ready_i;
  assign bus.arr_valid_o = in_load && bus.op_valid_i;
  assign bus.arr_data_o  = in_load ? bus.op_data_i : '0;

  assign bus.res_valid_o = in_drain && bus.arr_valid_i;
  assign bus.res_data_o  = in_drain ? bus.arr_data_i : '0;
  assign bus.arr_yumi_o  = res_fire;
  assign bus.res_row_o   = in_drain ? row_cnt : '0;
  assign bus.res_col_o   = in_drain ? col_cnt : '0;

endmodule

// File: doc/systolic_sched.md
# systolic_sched

Sequencing controller for the `systolic_array` datapath. It accepts a start command from the host and streams A then B operand beats into the array. It waits a fixed compute interval, then asserts flush and drains the C result matrix back to the host, tagging each result with its row and column. It sits between the host/loader FIFO and the array, and owns the array's `en_i`, `flush_i`, `valid_i` and `yumi_i` pins.

## Interface
- `width_p`, 8, operand and result word width
- `array_width_p`, 8, array columns (K dimension)
- `array_height_p`, 8, array rows (C is `array_height_p` × `array_height_p`)
- `compute_cycles_p`, 24, idle cycles between the last operand beat and the start of the drain
- `timeout_cycles_p`, 256, drain watchdog limit (used only with the macro)
- `clk_i`  in  1  clock; all logic is on the rising edge
- `reset_ni`  in  1  synchronous, active-low reset
- `start_i`  in  1  begin a job; sampled only in IDLE
- `busy_o`  out  1  high in LOAD, COMPUTE and DRAIN
- `done_o`  out  1  one-cycle pulse on job completion
- `err_o`  out  1  drain timeout flag; sticky until the next accepted `start_i`
- `op_valid_i` in 1, `op_data_i` in `width_p`, `op_ready_o` out 1: host operand stream
- `arr_en_o` out 1, `arr_flush_o` out 1: array control
- `arr_valid_o` out 1, `arr_data_o` out `width_p`, `arr_ready_i` in 1: array operand port
- `arr_valid_i` in 1, `arr_data_i` in `width_p`, `arr_yumi_o` out 1: array result port
- `res_valid_o` out 1, `res_data_o` out `width_p`, `res_row_o` out clog2(`array_height_p`), `res_col_o` out clog2(`array_height_p`), `res_ready_i` in 1: host result stream

## Operation
- **FSM states:** IDLE, LOAD, COMPUTE, DRAIN, DONE.
- **IDLE → LOAD:** on `start_i`. The beat, compute and result counters clear, and `err_o` clears.
- **LOAD:**
  - `arr_valid_o = op_valid_i`, `arr_data_o = op_data_i`, `op_ready_o = arr_ready_i` (combinational pass-through, gated by state).
  - A beat counts when `op_valid_i && arr_ready_i`.
  - The job is 2·`array_width_p`·`array_height_p` beats: A row-major, then B row-major.
  - The final beat moves the FSM to COMPUTE, or straight to DRAIN if `compute_cycles_p` = 0.
- **COMPUTE:** stays exactly `compute_cycles_p` cycles, then moves to DRAIN. `op_ready_o` = 0.
- **DRAIN:**
  - `arr_flush_o` = 1.
  - `res_valid_o = arr_valid_i`, `res_data_o = arr_data_i`, `arr_yumi_o = arr_valid_i && res_ready_i`.
  - Each handshake advances `res_col_o`. It wraps at `array_height_p`−1 and increments `res_row_o`.
  - After `array_height_p`² handshakes the FSM moves to DONE.
- **DONE:** `done_o` = 1 for one cycle, then IDLE.
- **`arr_en_o`:** 1 in every state except IDLE.
- **`start_i` when not in IDLE:** ignored, with no effect on the running job.
- **Counter widths:** clog2 of the terminal count + 1. Terminal compares use equality, so counters never wrap.

## Timing
- **Reset values:** all outputs are 0 (state IDLE, counters 0, `err_o` 0), which follows from IDLE gating.
- **Reset mid-job:** returns to IDLE the next edge, with no `done_o` and no partial result handshakes.
- **Start latency:** `start_i` high at edge t; `op_ready_o` can first be high in cycle t+1.
- **Last operand beat at edge t:** COMPUTE during cycles t+1 … t+`compute_cycles_p`; `arr_flush_o` first high in cycle t+`compute_cycles_p`+1.
- **Result flow control:** zero added latency on the result path; backpressure via `res_ready_i` stalls `arr_yumi_o` in the same cycle.
- **Last result handshake at edge t:** `done_o` = 1 in cycle t+1, `busy_o` = 0 in cycle t+1, IDLE in cycle t+2.
- **Boundary:** a `start_i` asserted in the same cycle as `done_o` is ignored (the FSM is in DONE, not IDLE).

## Configuration
- **Macro:** `SYSTOLIC_SCHED_TIMEOUT_EN`.
- **Defined:**
  - A watchdog counts consecutive DRAIN cycles with no result handshake.
  - When it reaches `timeout_cycles_p`: the FSM moves to DONE and sets `err_o` = 1.
  - `done_o` still pulses.
- **Undefined:** no watchdog logic is built, `err_o` is tied to 0, and DRAIN waits indefinitely.

## Structure
- **Package `systolic_pkg`:**
  - `sched_state_e` enum (IDLE, LOAD, COMPUTE, DRAIN, DONE).
  - Localparam functions for operand beat count, result count and counter widths.
- **Sub-module `sched_counter`:** parameterised up-counter with clear, enable and a terminal-count flag. Instantiated for the beat, compute and result counters, and for the watchdog.
- **FSM and handshake gating:** stay in `systolic_sched`.

## Test plan
All scenarios use defaults (8×8, `compute_cycles_p`=24) unless a scenario overrides them.
- **Nominal job:** `start_i` pulse, then 128 operand beats with `arr_ready_i`=1, then the array returns 64 results.
  - `arr_flush_o` rises exactly 25 cycles after the last beat.
  - Results carry row/col 0,0 … 7,7.
  - `done_o` pulses once and `busy_o` falls the same cycle.
- **Backpressure:**
  - `arr_ready_i` toggles 1,0,1,0: `op_ready_o` mirrors it, and exactly 128 beats are counted.
  - `res_ready_i`=0 for 10 cycles mid-drain: `arr_yumi_o`=0 and `res_col_o` holds.
- **Start while busy:** a `start_i` pulse during LOAD beat 50 has no effect; the job completes with exactly 128 beats.
- **Reset mid-DRAIN:** `reset_ni`=0 after result 20 gives all outputs 0 the next cycle and no `done_o`. A new start then runs a full job correctly.
- **`compute_cycles_p`=0:** the FSM goes from LOAD directly to DRAIN; `arr_flush_o` is high the cycle after the last beat.
- **Timeout (`SYSTOLIC_SCHED_TIMEOUT_EN`, `timeout_cycles_p`=16):** `arr_valid_i` stuck 0 in DRAIN.
  - `done_o` and `err_o` go high 17 cycles after DRAIN entry.
  - `err_o` holds until the next `start_i`.
